correlacion: RTL and testbench

Serial bit-correlator. Accepts a strobed serial bitstream. The first PATTERN_BITS bits after reset are stored as the reference pattern. Every later bit is shifted into a sliding sample window. After each 8 sample bits it reports the number of positions where the sample window and the pattern register agree. It sits between the serial front-end (bit + Read strobe) and the detection/threshold logic that consumes Data_Out on Flag.

---
 rtl/correlacion.sv | 150 +++++++++++++++
 tb/tb_correlacion.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/correlacion.sv
// Serial bit-correlator: loads a reference pattern from the first strobed bits, then
// reports how many window positions agree with a sliding sample register every few samples.
module correlacion #(
  parameter int unsigned PATTERN_BITS = 24,
  parameter int unsigned WINDOW       = 1024,
  parameter int unsigned REPORT_BITS  = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Bitstream,
  input  logic        Read,
  output logic [10:0] Data_Out,
  output logic        Flag
);

  localparam int unsigned OUT_W  = 11;
  localparam int unsigned CHUNK  = 32;
  localparam int unsigned NCHUNK = (WINDOW + CHUNK - 1) / CHUNK;
  localparam int unsigned PART_W = $clog2(CHUNK + 1);
  localparam int unsigned LCNT_W = $clog2(PATTERN_BITS + 1);
  localparam int unsigned SCNT_W = $clog2(REPORT_BITS + 1);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [1:0]          rd_sync_q;
  logic [1:0]          bs_sync_q;
  logic                rd_prev_q;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [WINDOW-1:0]   pat_q, pat_d;
  logic [WINDOW-1:0]   smp_q, smp_d;
  logic                rep0_q, rep0_d;
  logic                rep1_q, rep1_d;
  logic [PART_W-1:0]   part_q [NCHUNK];
  logic [PART_W-1:0]   part_d [NCHUNK];
  logic [OUT_W-1:0]    dout_q, dout_d;
  logic                flag_q, flag_d;

  logic                bit_ev_c;
  logic                bit_val_c;
  logic [WINDOW-1:0]   match_c;
  logic [OUT_W-1:0]    sum_c;

  assign bit_ev_c  = rd_sync_q[1] & ~rd_prev_q;
  assign bit_val_c = bs_sync_q[1];
  assign match_c   = ~(pat_q ^ smp_q);
  assign Data_Out  = dout_q;
  assign Flag      = flag_q;

  // Read chain resets high so a strobe already asserted at reset release is not seen as an edge.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_sync_q <= 2'b11;
      rd_prev_q <= 1'b1;
      bs_sync_q <= 2'b00;
    end else begin
      rd_sync_q <= {rd_sync_q[0], Read};
      rd_prev_q <= rd_sync_q[1];
      bs_sync_q <= {bs_sync_q[0], Bitstream};
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_LOAD;
      lcnt_q  <= '0;
      scnt_q  <= '0;
      pat_q   <= '0;
      smp_q   <= '0;
      rep0_q  <= 1'b0;
      rep1_q  <= 1'b0;
      dout_q  <= '0;
      flag_q  <= 1'b0;
      for (int c = 0; c < NCHUNK; c++) part_q[c] <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
      scnt_q  <= scnt_d;
      pat_q   <= pat_d;
      smp_q   <= smp_d;
      rep0_q  <= rep0_d;
      rep1_q  <= rep1_d;
      dout_q  <= dout_d;
      flag_q  <= flag_d;
      for (int c = 0; c < NCHUNK; c++) part_q[c] <= part_d[c];
    end
  end

  // First popcount stage: per-chunk agreement counts.
  always_comb begin
    for (int c = 0; c < NCHUNK; c++) begin
      part_d[c] = '0;
      for (int b = 0; b < CHUNK; b++) begin
        if (c * CHUNK + b < WINDOW) begin
          part_d[c] = part_d[c] + PART_W'(match_c[c * CHUNK + b]);
        end
      end
    end
  end

  // Second popcount stage: total of the chunk counts.
  always_comb begin
    sum_c = '0;
    for (int c = 0; c < NCHUNK; c++) begin
      sum_c = sum_c + OUT_W'(part_q[c]);
    end
  end

  // Next-state: pattern load, sample shifting, report launch and result pipeline.
  always_comb begin
    state_d = state_q;
    lcnt_d  = lcnt_q;
    scnt_d  = scnt_q;
    pat_d   = pat_q;
    smp_d   = smp_q;
    rep0_d  = 1'b0;
    rep1_d  = rep0_q;
    flag_d  = rep1_q;
    dout_d  = rep1_q ? sum_c : dout_q;

    case (state_q)
      ST_LOAD: begin
        if (bit_ev_c) begin
          pat_d  = {pat_q[WINDOW-2:0], bit_val_c};
          lcnt_d = lcnt_q + LCNT_W'(1);
          if (lcnt_q == LCNT_W'(PATTERN_BITS - 1)) begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (bit_ev_c) begin
          smp_d = {smp_q[WINDOW-2:0], bit_val_c};
          if (scnt_q == SCNT_W'(REPORT_BITS - 1)) begin
            scnt_d = '0;
            rep0_d = 1'b1;
          end else begin
            scnt_d = scnt_q + SCNT_W'(1);
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

endmodule

// File: tb/tb_correlacion.sv
// Bench for correlacion: table vectors, random bytes and hand-written reset/strobe
// sequences, all scored against a bit-list model of pattern and sample history.
module tb_correlacion;

  localparam int unsigned PB  = 24;
  localparam int unsigned WIN = 1024;
  localparam int unsigned RB  = 8;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Bitstream;
  logic        Read;
  logic [10:0] Data_Out;
  logic        Flag;

  always #5 Clk = ~Clk;

  correlacion #(.PATTERN_BITS(PB), .WINDOW(WIN), .REPORT_BITS(RB)) dut (
    .Clk(Clk), .Reset(Reset), .Bitstream(Bitstream), .Read(Read),
    .Data_Out(Data_Out), .Flag(Flag)
  );

  int errors = 0;
  int checks = 0;
  bit pat[$];
  bit smp[$];
  int exp_q[$];
  int last_val = 0;
  int flags_seen = 0;
  logic flag_prev = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Bit i of each register is the i-th most recent bit delivered to it; absent bits are 0.
  function automatic int model_count();
    int m = 0;
    for (int i = 0; i < WIN; i++) begin
      bit p = (i < pat.size()) ? pat[pat.size() - 1 - i] : 1'b0;
      bit s = (i < smp.size()) ? smp[smp.size() - 1 - i] : 1'b0;
      if (p == s) m++;
    end
    return m;
  endfunction

  function automatic int pattern_ones();
    int n = 0;
    foreach (pat[i]) n += int'(pat[i]);
    return n;
  endfunction

  task automatic model_reset();
    pat.delete();
    smp.delete();
    exp_q.delete();
  endtask

  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      if (Flag) begin
        flags_seen++;
        check("flag_width", int'(flag_prev), 0);
        check("report_pending", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) check("data_out", int'(Data_Out), exp_q.pop_front());
        last_val = int'(Data_Out);
      end
      flag_prev = Flag;
    end else begin
      flag_prev = 1'b0;
    end
  end

  task automatic send_bit(input bit b, input int hi, input int lo);
    int lat;
    bit rep;
    @(negedge Clk);
    Bitstream = b;
    repeat (2) @(negedge Clk);
    Read = 1'b1;
    rep  = 1'b0;
    lat  = -1;
    if (pat.size() < PB) begin
      pat.push_back(b);
    end else begin
      smp.push_back(b);
      if (smp.size() % RB == 0) begin
        exp_q.push_back(model_count());
        rep = 1'b1;
      end
    end
    for (int c = 1; c <= hi + lo; c++) begin
      @(negedge Clk);
      if (Flag && lat < 0) lat = c;
      if (c == hi) Read = 1'b0;
    end
    // Flag seen at the 5th falling edge after the raise = 4 cycles after the sampling edge.
    if (rep) check("latency", lat, 5);
  endtask

  task automatic send_byte(input logic [7:0] v, input int long_idx);
    for (int i = 0; i < 8; i++) send_bit(v[i], (i == long_idx) ? 20 : 5, 7);
  endtask

  typedef struct {
    logic [7:0] data;
    int         long_idx;
    int         exp_val;
  } vec_t;

  vec_t tv[4];

  initial begin
    int f0;
    tv[0] = '{8'd173, -1, 1011};
    tv[1] = '{8'd107, -1, 1012};
    tv[2] = '{8'd110, -1, 1017};
    tv[3] = '{8'd173,  3, 1010};

    Reset = 1'b0; Read = 1'b0; Bitstream = 1'b1;
    @(negedge Clk); Read = 1'b1;
    @(negedge Clk); Read = 1'b0;
    @(negedge Clk); Read = 1'b1;
    @(negedge Clk); Read = 1'b0;
    check("reset_data_out", int'(Data_Out), 0);
    check("reset_flag", int'(Flag), 0);
    Reset = 1'b1;
    repeat (3) @(negedge Clk);

    send_byte(8'd173, -1);
    send_byte(8'd109, -1);
    send_byte(8'd221, -1);
    check("no_flag_during_load", flags_seen, 0);

    for (int i = 0; i < 4; i++) begin
      f0 = flags_seen;
      send_byte(tv[i].data, tv[i].long_idx);
      check("table_value", last_val, tv[i].exp_val);
      check("table_flag_count", flags_seen - f0, 1);
    end

    for (int i = 0; i < 6; i++) send_byte(8'($urandom_range(0, 255)), -1);
    check("random_all_reported", exp_q.size(), 0);

    for (int i = 0; i < 1040; i++) send_bit(1'b0, 3, 3);
    check("zero_stream_final", last_val, WIN - pattern_ones());

    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)), 5, 7);
    @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("midstream_reset_data_out", int'(Data_Out), 0);
    check("midstream_reset_flag", int'(Flag), 0);
    model_reset();
    repeat (2) @(negedge Clk);
    Reset = 1'b1;
    f0 = flags_seen;
    repeat (8) @(negedge Clk);
    check("no_flag_after_reset", flags_seen - f0, 0);
    for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 255)), -1);
    check("reload_no_flag", flags_seen - f0, 0);
    for (int i = 0; i < 2; i++) send_byte(8'($urandom_range(0, 255)), -1);
    check("reload_reports", flags_seen - f0, 2);
    check("reload_all_reported", exp_q.size(), 0);

    // Reset while a report is in flight, released with Read still high.
    for (int i = 0; i < 7; i++) send_bit(1'($urandom_range(0, 1)), 5, 7);
    @(negedge Clk); Bitstream = 1'b0;
    repeat (2) @(negedge Clk);
    Read = 1'b1;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    #1;
    check("inflight_reset_data_out", int'(Data_Out), 0);
    check("inflight_reset_flag", int'(Flag), 0);
    model_reset();
    @(negedge Clk);
    Reset = 1'b1;
    f0 = flags_seen;
    repeat (10) @(negedge Clk);
    Read = 1'b0;
    repeat (6) @(negedge Clk);
    check("inflight_discarded", flags_seen - f0, 0);
    for (int i = 0; i < 3; i++) send_byte(8'hFF, -1);
    send_byte(8'h00, -1);
    check("stale_read_ignored", last_val, 1000);
    check("final_all_reported", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
